// File: rtl/lbc_syndrome_decoder_pipe.sv
// Pipelined single-error-correcting syndrome decoder for a systematic (N,K) code.
// Codeword: parity bits at [R-1:0], data bits at [N-1:R]; H = [I_R | P].
// S1 registers the data and syndrome. S2 is the output register and resolves
// the error position, correction and flags. Saturating correction/uncorrectable counters.
module lbc_syndrome_decoder_pipe #(
   parameter int unsigned         N     = 14,
   parameter int unsigned         K     = 4,
   parameter logic [(N-K)*K-1:0]  P     = {10'h3E0, 10'h31C, 10'h0DA, 10'h2B7},
   parameter int unsigned         CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           cx_in,
   input  logic                   correct_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [K-1:0]           d_out,
   output logic [N-K-1:0]         syndrome,
   output logic                   err_corr,
   output logic                   err_det,
   output logic                   err_uncorr,
   output logic [$clog2(N)-1:0]   err_pos,
   input  logic                   cnt_clr,
   output logic [CNT_W-1:0]       cnt_corr,
   output logic [CNT_W-1:0]       cnt_uncorr
);

   localparam int unsigned R  = N - K;
   localparam int unsigned PW = $clog2(N);

   // Stage 1 state. Parity bits are only needed for the syndrome, so only data is kept.
   logic           s1_valid_q, s1_valid_d;
   logic [K-1:0]   s1_data_q, s1_data_d;
   logic           s1_cen_q, s1_cen_d;
   logic [R-1:0]   s1_syn_q, s1_syn_d;

   // Stage 2 (output register) state
   logic           out_valid_q, out_valid_d;
   logic [K-1:0]   d_out_q, d_out_d;
   logic [R-1:0]   syn_q, syn_d;
   logic           corr_q, corr_d;
   logic           det_q, det_d;
   logic           uncorr_q, uncorr_d;
   logic [PW-1:0]  pos_q, pos_d;

   logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
   logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;

   logic           s2_adv;
   logic           s1_adv;
   logic           out_xfer;
   logic [R-1:0]   syn_in;
   logic           hit;
   logic [PW-1:0]  hit_pos;
   logic [K-1:0]   flip;
   logic           syn_nz;

   // Handshake: stages advance when empty or when the stage ahead moves
   always_comb begin
      s2_adv   = !out_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      in_ready = s1_adv;
      out_xfer = out_valid_q && out_ready;
   end

   // Syndrome of the incoming word: parity bits XOR the P columns of set data bits
   always_comb begin
      syn_in = cx_in[R-1:0];
      for (int k = 0; k < K; k++) begin
         if (cx_in[R+k]) begin
            syn_in = syn_in ^ P[k*R +: R];
         end
      end
   end

   // Column match on the S1 syndrome; ascending scan so the lowest index wins
   always_comb begin
      hit     = 1'b0;
      hit_pos = '0;
      flip    = '0;
      syn_nz  = (s1_syn_q != '0);
      for (int i = 0; i < R; i++) begin
         if (syn_nz && !hit && (s1_syn_q == (R'(1) << i))) begin
            hit     = 1'b1;
            hit_pos = PW'(i);
         end
      end
      for (int k = 0; k < K; k++) begin
         if (syn_nz && !hit && (s1_syn_q == P[k*R +: R])) begin
            hit     = 1'b1;
            hit_pos = PW'(R + k);
            flip[k] = 1'b1;
         end
      end
   end

   // Stage 1 next state: load on accept
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_cen_d   = s1_cen_q;
      s1_syn_d   = s1_syn_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = cx_in[N-1:R];
            s1_cen_d  = correct_en;
            s1_syn_d  = syn_in;
         end
      end
   end

   // Stage 2 next state: results held while stalled
   always_comb begin
      out_valid_d = out_valid_q;
      d_out_d     = d_out_q;
      syn_d       = syn_q;
      corr_d      = corr_q;
      det_d       = det_q;
      uncorr_d    = uncorr_q;
      pos_d       = pos_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            corr_d   = hit && s1_cen_q;
            det_d    = syn_nz;
            uncorr_d = syn_nz && !hit;
            syn_d    = s1_syn_q;
            pos_d    = (hit && s1_cen_q) ? hit_pos : '0;
            // A parity-bit hit leaves flip at zero, so data passes through unchanged
            d_out_d  = s1_data_q ^ ((hit && s1_cen_q) ? flip : '0);
         end
      end
   end

   // Saturating counters; clear wins over a same-cycle increment
   always_comb begin
      cnt_corr_d   = cnt_corr_q;
      cnt_uncorr_d = cnt_uncorr_q;
      if (cnt_clr) begin
         cnt_corr_d   = '0;
         cnt_uncorr_d = '0;
      end else begin
         if (out_xfer && corr_q && (cnt_corr_q != {CNT_W{1'b1}})) begin
            cnt_corr_d = cnt_corr_q + CNT_W'(1);
         end
         if (out_xfer && uncorr_q && (cnt_uncorr_q != {CNT_W{1'b1}})) begin
            cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_cen_q     <= 1'b0;
         s1_syn_q     <= '0;
         out_valid_q  <= 1'b0;
         d_out_q      <= '0;
         syn_q        <= '0;
         corr_q       <= 1'b0;
         det_q        <= 1'b0;
         uncorr_q     <= 1'b0;
         pos_q        <= '0;
         cnt_corr_q   <= '0;
         cnt_uncorr_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_data_q    <= s1_data_d;
         s1_cen_q     <= s1_cen_d;
         s1_syn_q     <= s1_syn_d;
         out_valid_q  <= out_valid_d;
         d_out_q      <= d_out_d;
         syn_q        <= syn_d;
         corr_q       <= corr_d;
         det_q        <= det_d;
         uncorr_q     <= uncorr_d;
         pos_q        <= pos_d;
         cnt_corr_q   <= cnt_corr_d;
         cnt_uncorr_q <= cnt_uncorr_d;
      end
   end

   // Output drive
   always_comb begin
      out_valid  = out_valid_q;
      d_out      = d_out_q;
      syndrome   = syn_q;
      err_corr   = corr_q;
      err_det    = det_q;
      err_uncorr = uncorr_q;
      err_pos    = pos_q;
      cnt_corr   = cnt_corr_q;
      cnt_uncorr = cnt_uncorr_q;
   end

endmodule

// File: tb/tb_lbc_syndrome_decoder_pipe.sv
// Scoreboard bench for lbc_syndrome_decoder_pipe, default (14,4) code, CNT_W=2.
module tb_lbc_syndrome_decoder_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [13:0] cx_in;
   logic        correct_en;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  d_out;
   logic [9:0]  syndrome;
   logic        err_corr;
   logic        err_det;
   logic        err_uncorr;
   logic [3:0]  err_pos;
   logic        cnt_clr;
   logic [1:0]  cnt_corr;
   logic [1:0]  cnt_uncorr;

   typedef struct packed {
      logic [3:0] d;
      logic [9:0] syn;
      logic       corr;
      logic       det;
      logic       unc;
      logic [3:0] pos;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Backpressure control: pattern 1,0,0,1 when bp_en, else or_val
   logic       bp_en  = 1'b0;
   logic       or_val = 1'b1;
   logic [3:0] pat    = 4'b1001;
   int         pidx   = 0;

   lbc_syndrome_decoder_pipe #(
      .CNT_W (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cx_in      (cx_in),
      .correct_en (correct_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .d_out      (d_out),
      .syndrome   (syndrome),
      .err_corr   (err_corr),
      .err_det    (err_det),
      .err_uncorr (err_uncorr),
      .err_pos    (err_pos),
      .cnt_clr    (cnt_clr),
      .cnt_corr   (cnt_corr),
      .cnt_uncorr (cnt_uncorr)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] d, input logic [9:0] s, input logic c,
                               input logic det, input logic u, input logic [3:0] p);
      exp_t e;
      e.d = d; e.syn = s; e.corr = c; e.det = det; e.unc = u; e.pos = p;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one word; expectation is queued at the accepting edge
   task automatic send(input logic [13:0] cx, input logic cen, input exp_t e);
      int w = 0;
      in_valid   = 1'b1;
      cx_in      = cx;
      correct_en = cen;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("accept_wait", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      if (in_ready) sb.push_back(e);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain", sb.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // out_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (bp_en) begin
            out_ready = pat[pidx];
            pidx      = (pidx + 1) % 4;
         end else begin
            out_ready = or_val;
         end
      end
   end

   // Monitor: compare every presented output against the queue head, pop on transfer
   initial begin
      int   n;
      exp_t act;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            n = sb.size();
            chk("in_ready", {31'd0, in_ready}, {31'd0, (n < 2) || out_ready});
            if (out_valid) begin
               if (n == 0) begin
                  chk("unexpected_output", {31'd0, out_valid}, 32'd0);
               end else begin
                  act = {d_out, syndrome, err_corr, err_det, err_uncorr, err_pos};
                  chk("out_word", {11'd0, act}, {11'd0, sb[0]});
                  if (out_ready) void'(sb.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      cx_in      = '0;
      correct_en = 1'b0;
      cnt_clr    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_d_out", {28'd0, d_out}, 32'd0);
      chk("rst_syndrome", {22'd0, syndrome}, 32'd0);
      chk("rst_flags", {29'd0, err_corr, err_det, err_uncorr}, 32'd0);
      chk("rst_pos", {28'd0, err_pos}, 32'd0);
      chk("rst_cnts", {28'd0, cnt_corr, cnt_uncorr}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed single words
      send(14'h06B7, 1'b1, mk(4'h1, 10'h000, 1'b0, 1'b0, 1'b0, 4'd0));
      drain();
      chk("clean_cnt_corr", {30'd0, cnt_corr}, 32'd0);
      chk("clean_cnt_uncorr", {30'd0, cnt_uncorr}, 32'd0);
      send(14'h06BF, 1'b1, mk(4'h1, 10'h008, 1'b1, 1'b1, 1'b0, 4'd3));
      send(14'h02B7, 1'b1, mk(4'h1, 10'h2B7, 1'b1, 1'b1, 1'b0, 4'd10));
      send(14'h02B7, 1'b0, mk(4'h0, 10'h2B7, 1'b0, 1'b1, 1'b0, 4'd0));
      send(14'h06B4, 1'b1, mk(4'h1, 10'h003, 1'b0, 1'b1, 1'b1, 4'd0));
      drain();
      chk("dir_cnt_corr", {30'd0, cnt_corr}, 32'd2);
      chk("dir_cnt_uncorr", {30'd0, cnt_uncorr}, 32'd1);

      // Backpressure stream, out_ready 1,0,0,1
      bp_en = 1'b1;
      send(14'h08DA, 1'b1, mk(4'h2, 10'h000, 1'b0, 1'b0, 1'b0, 4'd0));
      send(14'h0E6D, 1'b1, mk(4'h3, 10'h000, 1'b0, 1'b0, 1'b0, 4'd0));
      send(14'h331C, 1'b1, mk(4'h4, 10'h3E0, 1'b1, 1'b1, 1'b0, 4'd13));
      send(14'h23E1, 1'b1, mk(4'h8, 10'h001, 1'b1, 1'b1, 1'b0, 4'd0));
      send(14'h3E91, 1'b1, mk(4'hF, 10'h000, 1'b0, 1'b0, 1'b0, 4'd0));
      send(14'h0800, 1'b1, mk(4'h0, 10'h0DA, 1'b1, 1'b1, 1'b0, 4'd11));
      send(14'h3000, 1'b1, mk(4'hC, 10'h0FC, 1'b0, 1'b1, 1'b1, 4'd0));
      send(14'h3C91, 1'b0, mk(4'hF, 10'h200, 1'b0, 1'b1, 1'b0, 4'd0));
      drain();
      bp_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_cnt_corr_sat", {30'd0, cnt_corr}, 32'd3);
      chk("bp_cnt_uncorr", {30'd0, cnt_uncorr}, 32'd2);

      // Reset with two words in flight
      send(14'h06B7, 1'b1, mk(4'h1, 10'h000, 1'b0, 1'b0, 1'b0, 4'd0));
      send(14'h06B7, 1'b1, mk(4'h1, 10'h000, 1'b0, 1'b0, 1'b0, 4'd0));
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_cnts", {28'd0, cnt_corr, cnt_uncorr}, 32'd0);
      chk("midrst_d_out", {28'd0, d_out}, 32'd0);
      #10;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

      // Saturation from zero with five correctable words
      repeat (5) send(14'h06BF, 1'b1, mk(4'h1, 10'h008, 1'b1, 1'b1, 1'b0, 4'd3));
      drain();
      chk("sat_cnt_corr", {30'd0, cnt_corr}, 32'd3);

      // Clear alone
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      chk("clr_cnt_corr", {30'd0, cnt_corr}, 32'd0);
      send(14'h06BF, 1'b1, mk(4'h1, 10'h008, 1'b1, 1'b1, 1'b0, 4'd3));
      drain();
      chk("one_cnt_corr", {30'd0, cnt_corr}, 32'd1);

      // Clear in the same cycle as an incrementing transfer
      or_val = 1'b0;
      @(posedge clk);
      #3;
      send(14'h06BF, 1'b1, mk(4'h1, 10'h008, 1'b1, 1'b1, 1'b0, 4'd3));
      repeat (3) @(posedge clk);
      #3;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      or_val = 1'b1;
      @(posedge clk);
      #3;
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      chk("clr_xfer_cnt_corr", {30'd0, cnt_corr}, 32'd0);
      chk("clr_xfer_sb_empty", sb.size(), 32'd0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
